// File: rtl/feature_map_serializer_if.sv
// Handshake bundle between the conv stage, the feature map serializer and the
// post-processing consumer: a parallel vector in, a one-channel-per-beat stream out.
interface feature_map_serializer_if #(
  parameter int FEATURE_WIDTH = 16,
  parameter int NUM_FILTERS   = 6
);
  localparam int CHANNEL_WIDTH = $clog2(NUM_FILTERS);

  logic                                      i_features_valid;
  logic [NUM_FILTERS-1:0][FEATURE_WIDTH-1:0] i_features;
  logic                                      o_ready;
  logic                                      o_overflow;
  logic                                      o_valid;
  logic                                      i_ready;
  logic signed [FEATURE_WIDTH-1:0]           o_feature;
  logic [CHANNEL_WIDTH-1:0]                  o_channel;
  logic                                      o_last;

  // master is the environment (producer + consumer); slave is the serializer
  modport master (
    output i_features_valid, i_features, i_ready,
    input  o_ready, o_overflow, o_valid, o_feature, o_channel, o_last
  );

  modport slave (
    input  i_features_valid, i_features, i_ready,
    output o_ready, o_overflow, o_valid, o_feature, o_channel, o_last
  );
endinterface

// File: rtl/feature_map_serializer.sv
// Serializes parallel conv feature vectors into a one-channel-per-beat valid/ready
// stream, buffering whole vectors in a small FIFO and optionally clamping negatives.
module feature_map_serializer #(
  parameter int FEATURE_WIDTH = 16,
  parameter int NUM_FILTERS   = 6,
  parameter int FIFO_DEPTH    = 4,
  parameter bit RELU          = 1'b1
) (
  input logic                     i_clk,
  input logic                     i_rst_n,
  feature_map_serializer_if.slave fm
);
  localparam int CH_W  = $clog2(NUM_FILTERS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [NUM_FILTERS-1:0][FEATURE_WIDTH-1:0] vec_t;
  typedef enum logic {IDLE, STREAM} state_t;

  logic [1:0]               rst_sync_q;
  logic                     rst_n;
  state_t                   state_q, state_d;
  vec_t                     mem [FIFO_DEPTH];
  vec_t                     vec_q;
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]         count_q;
  logic [CH_W-1:0]          channel_q, next_channel;
  logic [FEATURE_WIDTH-1:0] feature_q;
  logic                     last_q, overflow_q;
  logic                     full, empty, push, pop, load, advance;

  function automatic logic [FEATURE_WIDTH-1:0] apply_relu(input logic [FEATURE_WIDTH-1:0] value);
    if (RELU && value[FEATURE_WIDTH-1]) return '0;
    return value;
  endfunction

  // Reset asserts asynchronously but is released only on a clock edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign full         = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty        = (count_q == '0);
  assign push         = fm.i_features_valid && !full;
  assign next_channel = channel_q + CH_W'(1);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          load    = 1'b1;
          pop     = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (fm.i_ready) begin
          if (!last_q) begin
            advance = 1'b1;
          end else if (!empty) begin
            // Chain straight into the next vector so consecutive vectors have no bubble
            load = 1'b1;
            pop  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= fm.i_features;
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      if (fm.i_features_valid && full) overflow_q <= 1'b1;
    end
  end

  // The output beat is registered, so the ReLU result is computed one step ahead
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q     <= '0;
      channel_q <= '0;
      feature_q <= '0;
      last_q    <= 1'b0;
    end else if (load) begin
      vec_q     <= mem[rd_ptr_q];
      channel_q <= '0;
      feature_q <= apply_relu(mem[rd_ptr_q][0]);
      last_q    <= 1'b0;
    end else if (advance) begin
      channel_q <= next_channel;
      feature_q <= apply_relu(vec_q[next_channel]);
      last_q    <= (next_channel == CH_W'(NUM_FILTERS - 1));
    end
  end

  assign fm.o_ready    = !full;
  assign fm.o_overflow = overflow_q;
  assign fm.o_valid    = (state_q == STREAM);
  assign fm.o_feature  = feature_q;
  assign fm.o_channel  = channel_q;
  assign fm.o_last     = last_q;
endmodule

// File: tb/tb_feature_map_serializer.sv
// Scoreboard bench for feature_map_serializer: one ReLU and one pass-through instance
// share stimulus, and every output beat is compared against its own expected queue.
module tb_feature_map_serializer;
  localparam int FW    = 16;
  localparam int NF    = 6;
  localparam int DEPTH = 4;

  typedef logic [NF-1:0][FW-1:0] vec_t;
  typedef struct {
    int feature;
    int channel;
    bit last;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b1;
  int    checks = 0;
  int    errors = 0;
  bit    contig_mode = 1'b0;
  beat_t exp_q0[$];
  beat_t exp_q1[$];
  beat_t mon_beat;

  logic          mon_valid   [2];
  logic [FW-1:0] mon_feature [2];
  logic [2:0]    mon_channel [2];
  logic          mon_last    [2];

  feature_map_serializer_if #(.FEATURE_WIDTH(FW), .NUM_FILTERS(NF)) fm_relu ();
  feature_map_serializer_if #(.FEATURE_WIDTH(FW), .NUM_FILTERS(NF)) fm_raw ();

  assign fm_raw.i_features_valid = fm_relu.i_features_valid;
  assign fm_raw.i_features       = fm_relu.i_features;
  assign fm_raw.i_ready          = fm_relu.i_ready;

  feature_map_serializer #(.FEATURE_WIDTH(FW), .NUM_FILTERS(NF), .FIFO_DEPTH(DEPTH), .RELU(1'b1))
    dut_relu (.i_clk(clk), .i_rst_n(rst_n), .fm(fm_relu));
  feature_map_serializer #(.FEATURE_WIDTH(FW), .NUM_FILTERS(NF), .FIFO_DEPTH(DEPTH), .RELU(1'b0))
    dut_raw (.i_clk(clk), .i_rst_n(rst_n), .fm(fm_raw));

  assign mon_valid[0]   = fm_relu.o_valid;
  assign mon_feature[0] = fm_relu.o_feature;
  assign mon_channel[0] = fm_relu.o_channel;
  assign mon_last[0]    = fm_relu.o_last;
  assign mon_valid[1]   = fm_raw.o_valid;
  assign mon_feature[1] = fm_raw.o_feature;
  assign mon_channel[1] = fm_raw.o_channel;
  assign mon_last[1]    = fm_raw.o_last;

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic beat_t q_peek(input int d);
    return (d == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  function automatic void q_pop(input int d);
    if (d == 0) void'(exp_q0.pop_front());
    else        void'(exp_q1.pop_front());
  endfunction

  // Expected beats: index 0 is the ReLU instance, index 1 the pass-through one
  function automatic void push_expected(input vec_t vec);
    beat_t b;
    int    value;
    for (int c = 0; c < NF; c++) begin
      value     = $signed(vec[c]);
      b.channel = c;
      b.last    = (c == NF - 1);
      b.feature = value;
      exp_q1.push_back(b);
      b.feature = (value < 0) ? 0 : value;
      exp_q0.push_back(b);
    end
  endfunction

  // Peek-compare every valid cycle so a stalled beat must stay equal to the head entry
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mon_valid[d] === 1'b1) begin
        if (d == 0 && contig_mode && q_size(0) != 0) check_output("no_bubble", mon_valid[0], 1);
        if (q_size(d) == 0) begin
          check_output($sformatf("stray_beat_dut%0d", d), 1, 0);
        end else begin
          mon_beat = q_peek(d);
          check_output($sformatf("feature_dut%0d_ch%0d", d, mon_beat.channel),
                       longint'($signed(mon_feature[d])), mon_beat.feature);
          check_output($sformatf("channel_dut%0d", d), mon_channel[d], mon_beat.channel);
          check_output($sformatf("last_dut%0d_ch%0d", d, mon_beat.channel), mon_last[d], mon_beat.last);
          if (fm_relu.i_ready) q_pop(d);
        end
      end else if (d == 0 && contig_mode && q_size(0) != 0) begin
        check_output("no_bubble", mon_valid[0], 1);
      end
    end
  end

  // Called just after a rising edge; the vector is captured on the next edge
  task automatic apply_stimulus(input vec_t vec, input bit accept);
    fm_relu.i_features_valid = 1'b1;
    fm_relu.i_features       = vec;
    if (accept) push_expected(vec);
    @(posedge clk);
    #1;
    fm_relu.i_features_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
      @(posedge clk);
      #2;
    end
    check_output("drain_remaining", exp_q0.size() + exp_q1.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_valid"}, fm_relu.o_valid + fm_raw.o_valid, 0);
    check_output({tag, "_feature"}, fm_relu.o_feature, 0);
    check_output({tag, "_channel"}, fm_relu.o_channel, 0);
    check_output({tag, "_last"}, fm_relu.o_last, 0);
    check_output({tag, "_overflow"}, fm_relu.o_overflow, 0);
    check_output({tag, "_ready"}, fm_relu.o_ready & fm_raw.o_ready, 1);
  endtask

  task automatic single_vector(input vec_t vec, input string tag);
    apply_stimulus(vec, 1'b1);
    @(negedge clk);
    check_output({tag, "_latency_valid_early"}, fm_relu.o_valid, 0);
    @(negedge clk);
    check_output({tag, "_latency_valid"}, fm_relu.o_valid, 1);
    check_output({tag, "_latency_channel"}, fm_relu.o_channel, 0);
    wait_drain(40);
    check_output({tag, "_idle_after"}, fm_relu.o_valid + fm_raw.o_valid, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vec;
    int   sent;
    bit   found;

    fm_relu.i_features_valid = 1'b0;
    fm_relu.i_features       = '0;
    fm_relu.i_ready          = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] single vector, ReLU and pass-through");
    vec[0] = 16'sd10;  vec[1] = -16'sd5; vec[2] = 16'sd300;
    vec[3] = 16'h8000; vec[4] = 16'sd0;  vec[5] = 16'sd32767;
    single_vector(vec, "single");

    $display("[TB] back-to-back vectors");
    for (int v = 0; v < 3; v++) begin
      for (int c = 0; c < NF; c++) vec[c] = FW'(v * 100 + c - 3);
      apply_stimulus(vec, 1'b1);
    end
    contig_mode = 1'b1;
    wait_drain(60);
    contig_mode = 1'b0;

    $display("[TB] stall and overflow");
    fm_relu.i_ready = 1'b0;
    for (int v = 0; v < 5; v++) begin
      for (int c = 0; c < NF; c++) vec[c] = FW'(1000 * (v + 1) - c * 700);
      apply_stimulus(vec, 1'b1);
    end
    check_output("full_ready", fm_relu.o_ready, 0);
    check_output("overflow_before", fm_relu.o_overflow, 0);
    for (int c = 0; c < NF; c++) vec[c] = 16'h7777;
    apply_stimulus(vec, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check_output("overflow_sticky", fm_relu.o_overflow, 1);
    check_output("stall_channel", fm_relu.o_channel, 0);
    check_output("stall_valid", fm_relu.o_valid, 1);
    fm_relu.i_ready = 1'b1;
    wait_drain(80);
    check_output("overflow_held", fm_relu.o_overflow & fm_raw.o_overflow, 1);
    check_output("ready_after_drain", fm_relu.o_ready, 1);

    $display("[TB] random backpressure");
    sent = 0;
    for (int cyc = 0; cyc < 3000 && sent < 20; cyc++) begin
      fm_relu.i_ready = ($urandom_range(0, 2) != 0);
      if (fm_relu.o_ready && $urandom_range(0, 2) != 0) begin
        for (int c = 0; c < NF; c++) vec[c] = FW'($urandom);
        fm_relu.i_features_valid = 1'b1;
        fm_relu.i_features       = vec;
        push_expected(vec);
        sent++;
      end else begin
        fm_relu.i_features_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    fm_relu.i_features_valid = 1'b0;
    check_output("random_sent", sent, 20);
    fm_relu.i_ready = 1'b1;
    wait_drain(300);

    $display("[TB] reset mid-stream");
    for (int v = 0; v < 3; v++) begin
      for (int c = 0; c < NF; c++) vec[c] = FW'(50 * v + c + 1);
      apply_stimulus(vec, 1'b1);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (fm_relu.o_valid && fm_relu.o_channel == 3) found = 1'b1;
    end
    check_output("midstream_reached_ch3", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    exp_q0.delete();
    exp_q1.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_output("post_reset_idle", fm_relu.o_valid + fm_raw.o_valid, 0);
    vec[0] = -16'sd1; vec[1] = 16'sd2;   vec[2] = -16'sd3;
    vec[3] = 16'sd4;  vec[4] = -16'sd500; vec[5] = 16'sd6;
    single_vector(vec, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
